// File: rtl/decode_stage.sv
// Instruction-decode pipeline stage: splits an instruction word into RL/RR/RD/OP
// and registers them with valid, stall and flush control.
module decode_stage #(
    parameter int REG_W = 5,
    parameter int OP_W  = 2,
    parameter int ISIZE = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ISIZE-1:0] inst,
    input  logic             inst_valid,
    input  logic             stall,
    input  logic             flush,
    output logic [REG_W-1:0] rl,
    output logic [REG_W-1:0] rr,
    output logic [REG_W-1:0] rd,
    output logic [OP_W-1:0]  op,
    output logic             is_add,
    output logic             is_sub,
    output logic             is_mul,
    output logic             is_div,
    output logic             valid
);

    localparam int OP_LSB = 0;
    localparam int RD_LSB = OP_W;
    localparam int RR_LSB = OP_W + REG_W;
    localparam int RL_LSB = OP_W + 2 * REG_W;

    logic [REG_W-1:0] rl_reg, rr_reg, rd_reg;
    logic [OP_W-1:0]  op_reg;
    logic             valid_reg;
    logic [3:0]       op_hot;

    // Flush outranks stall; field registers only move on an accepted instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rl_reg    <= '0;
            rr_reg    <= '0;
            rd_reg    <= '0;
            op_reg    <= '0;
            valid_reg <= 1'b0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (!stall) begin
            valid_reg <= inst_valid;
            if (inst_valid) begin
                rl_reg <= inst[RL_LSB +: REG_W];
                rr_reg <= inst[RR_LSB +: REG_W];
                rd_reg <= inst[RD_LSB +: REG_W];
                op_reg <= inst[OP_LSB +: OP_W];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_op_hot
            assign op_hot[gi] = valid_reg && (op_reg == OP_W'(gi));
        end
    endgenerate

    assign rl     = rl_reg;
    assign rr     = rr_reg;
    assign rd     = rd_reg;
    assign op     = op_reg;
    assign valid  = valid_reg;
    assign is_add = op_hot[0];
    assign is_sub = op_hot[1];
    assign is_mul = op_hot[2];
    assign is_div = op_hot[3];

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] inst;
    logic        inst_valid;
    logic        stall;
    logic        flush;
    logic [4:0]  rl, rr, rd;
    logic [1:0]  op;
    logic        is_add, is_sub, is_mul, is_div, valid;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid),
        .stall(stall), .flush(flush),
        .rl(rl), .rr(rr), .rd(rd), .op(op),
        .is_add(is_add), .is_sub(is_sub), .is_mul(is_mul), .is_div(is_div),
        .valid(valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [4:0] erl,
                           input logic [4:0] err, input logic [4:0] erd,
                           input logic [1:0] eop, input logic [3:0] ehot);
        $display("[TB] %s: valid=%0b rl=%0d rr=%0d rd=%0d op=%0d hot=%b",
                 tag, valid, rl, rr, rd, op, {is_div, is_mul, is_sub, is_add});
        chk({tag, ".valid"}, {31'd0, valid}, {31'd0, ev});
        chk({tag, ".rl"}, {27'd0, rl}, {27'd0, erl});
        chk({tag, ".rr"}, {27'd0, rr}, {27'd0, err});
        chk({tag, ".rd"}, {27'd0, rd}, {27'd0, erd});
        chk({tag, ".op"}, {30'd0, op}, {30'd0, eop});
        chk({tag, ".hot"}, {28'd0, is_div, is_mul, is_sub, is_add}, {28'd0, ehot});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; inst = '0; inst_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        #3;
        chk_all("reset", 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        // Basic decode: MUL $10, $12, $11
        inst = 17'b01100_01011_01010_10; inst_valid = 1'b1;
        step();
        chk_all("basic", 1'b1, 5'd12, 5'd11, 5'd10, 2'd2, 4'b0100);

        // Asynchronous reset mid-cycle, checked before the next edge
        #2 rst = 1'b1;
        #1 chk_all("async_rst", 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        // Every opcode in consecutive cycles
        for (int k = 0; k < 4; k++) begin
            inst = {5'd1, 5'd2, 5'd3, 2'(k)}; inst_valid = 1'b1;
            step();
            chk_all($sformatf("op%0d", k), 1'b1, 5'd1, 5'd2, 5'd3, 2'(k), 4'(1 << k));
        end

        // Field extremes
        inst = 17'h1FFFF;
        step();
        chk_all("all_ones", 1'b1, 5'd31, 5'd31, 5'd31, 2'd3, 4'b1000);
        inst = 17'h00000;
        step();
        chk_all("all_zero", 1'b1, 5'd0, 5'd0, 5'd0, 2'd0, 4'b0001);

        // Stall holds everything while inst keeps changing
        inst = {5'd7, 5'd8, 5'd9, 2'd1};
        step();
        chk_all("pre_stall", 1'b1, 5'd7, 5'd8, 5'd9, 2'd1, 4'b0010);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            inst = 17'h0AA55 ^ 17'(k * 17'h1234);
            step();
            chk_all($sformatf("stall%0d", k), 1'b1, 5'd7, 5'd8, 5'd9, 2'd1, 4'b0010);
        end

        // Flush beats stall
        flush = 1'b1;
        step();
        $display("[TB] flush: valid=%0b hot=%b", valid, {is_div, is_mul, is_sub, is_add});
        chk("flush.valid", {31'd0, valid}, 32'd0);
        chk("flush.hot", {28'd0, is_div, is_mul, is_sub, is_add}, 32'd0);
        flush = 1'b0; stall = 1'b0;

        // Bubble between two instructions
        inst = {5'd3, 5'd4, 5'd5, 2'd0}; inst_valid = 1'b1;
        step();
        chk_all("bubble_a", 1'b1, 5'd3, 5'd4, 5'd5, 2'd0, 4'b0001);
        inst = 17'h15555; inst_valid = 1'b0;
        step();
        chk_all("bubble_gap", 1'b0, 5'd3, 5'd4, 5'd5, 2'd0, 4'b0000);
        inst = {5'd6, 5'd7, 5'd8, 2'd3}; inst_valid = 1'b1;
        step();
        chk_all("bubble_b", 1'b1, 5'd6, 5'd7, 5'd8, 2'd3, 4'b1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
